// File: rtl/jb_pa_seq_pkg.sv
// jb_pa_seq_pkg: shared types and constants for the PA switch sequencer.
// Holds the sequencer state encoding and the safe pin values.
package jb_pa_seq_pkg;

    localparam int PA_SEQ_DLY_W = 16;
    localparam int PA_SEQ_N_PA  = 6;

    typedef enum logic [1:0] {
        ST_RX        = 2'd0,
        ST_TX_SETTLE = 2'd1,
        ST_TX        = 2'd2,
        ST_RX_SETTLE = 2'd3
    } pa_seq_state_t;

    localparam logic [PA_SEQ_N_PA:1] PA_EN_OFF = '1;
    localparam logic [PA_SEQ_N_PA:1] PA_SW_RX  = '1;

endpackage

// File: rtl/jb_ctrl_rf_control_if.sv
// jb_ctrl_rf_control_if: RF control register bundle from the ctrl regmap.
// The regmap drives it as master; the PA sequencer consumes it as slave.
interface jb_ctrl_rf_control_if;
    import jb_pa_seq_pkg::*;

    logic [PA_SEQ_DLY_W-1:0] ant_switch_delay;
    logic                    pa_switch_override;
    logic [PA_SEQ_N_PA:1]    pa_switch_en_n;
    logic [PA_SEQ_N_PA:1]    pa_switch_n;

    modport master (
        output ant_switch_delay,
        output pa_switch_override,
        output pa_switch_en_n,
        output pa_switch_n
    );

    modport slave (
        input ant_switch_delay,
        input pa_switch_override,
        input pa_switch_en_n,
        input pa_switch_n
    );

endinterface

// File: rtl/jb_pa_seq_timer.sv
// jb_pa_seq_timer: loadable settle down-counter, load value max(d,1).
// done is high while the count sits at 1; the count never wraps.
module jb_pa_seq_timer
    import jb_pa_seq_pkg::*;
#(
    parameter int DLY_W = PA_SEQ_DLY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [DLY_W-1:0] d,
    output logic             done
);

    logic [DLY_W-1:0] cnt;
    logic [DLY_W-1:0] ld_val;

    assign ld_val = (d == '0) ? DLY_W'(1) : d;
    assign done   = (cnt == DLY_W'(1));

    // Load on settle entry, count down to 1 and hold there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= ld_val;
        end else if (cnt > DLY_W'(1)) begin
            cnt <= cnt - DLY_W'(1);
        end
    end

endmodule

// File: rtl/jb_pa_switch_seq.sv
// jb_pa_switch_seq: break-before-make PA enable / T/R switch sequencer.
// Optional status outputs built when JB_PA_SEQ_STATUS_EN is defined.
module jb_pa_switch_seq
    import jb_pa_seq_pkg::*;
#(
    parameter int N_PA  = PA_SEQ_N_PA,
    parameter int DLY_W = PA_SEQ_DLY_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    jb_ctrl_rf_control_if.slave  rf_ctrl,
    input  logic                 tx_req,
    output logic [N_PA:1]        pa_en_n_o,
    output logic [N_PA:1]        pa_sw_n_o,
    output logic                 tx_active_o
`ifdef JB_PA_SEQ_STATUS_EN
    ,
    output logic [1:0]           seq_state_o,
    output logic [15:0]          abort_cnt_o
`endif
);

    pa_seq_state_t state;
    pa_seq_state_t nxt;

    logic            tx_q;
    logic            ovr_q;
    logic            ovr_hold;
    logic            load;
    logic            clr;
    logic            done;
    logic [N_PA:1]   act_live;
    logic [N_PA:1]   act_q;
    logic [N_PA:1]   act_nxt;
    logic [DLY_W-1:0] dly;

    assign act_live = N_PA'(~rf_ctrl.pa_switch_en_n);
    assign dly      = DLY_W'(rf_ctrl.ant_switch_delay);

    // Active-path mask is frozen once a sequence leaves RX.
    assign act_nxt  = (state == ST_RX) ? act_live : act_q;

    jb_pa_seq_timer #(
        .DLY_W (DLY_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .clear (clr),
        .d     (dly),
        .done  (done)
    );

    // Register the request and override controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q     <= 1'b0;
            ovr_q    <= 1'b0;
            ovr_hold <= 1'b0;
        end else begin
            tx_q     <= tx_req;
            ovr_q    <= rf_ctrl.pa_switch_override;
            ovr_hold <= ovr_q;
        end
    end

    // Next state and settle timer control.
    always_comb begin
        nxt  = state;
        load = 1'b0;
        clr  = 1'b0;
        if (ovr_q || ovr_hold) begin
            nxt = ST_RX;
            clr = 1'b1;
        end else begin
            unique case (state)
                ST_RX: begin
                    if (tx_q) begin
                        nxt  = ST_TX_SETTLE;
                        load = 1'b1;
                    end
                end
                ST_TX_SETTLE: begin
                    if (!tx_q) begin
                        nxt  = ST_RX_SETTLE;
                        load = 1'b1;
                    end else if (done) begin
                        nxt = ST_TX;
                        clr = 1'b1;
                    end
                end
                ST_TX: begin
                    if (!tx_q) begin
                        nxt  = ST_RX_SETTLE;
                        load = 1'b1;
                    end
                end
                ST_RX_SETTLE: begin
                    if (tx_q) begin
                        nxt  = ST_TX_SETTLE;
                        load = 1'b1;
                    end else if (done) begin
                        nxt = ST_RX;
                        clr = 1'b1;
                    end
                end
                default: nxt = ST_RX;
            endcase
        end
    end

    // State register with pins derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RX;
            act_q       <= '0;
            pa_en_n_o   <= '1;
            pa_sw_n_o   <= '1;
            tx_active_o <= 1'b0;
        end else begin
            state <= nxt;
            act_q <= act_nxt;
            if (ovr_q) begin
                pa_en_n_o   <= N_PA'(rf_ctrl.pa_switch_en_n);
                pa_sw_n_o   <= N_PA'(rf_ctrl.pa_switch_n);
                tx_active_o <= 1'b0;
            end else begin
                pa_en_n_o   <= (nxt == ST_TX) ? ~act_nxt : '1;
                pa_sw_n_o   <= (nxt == ST_RX) ? '1 : ~act_nxt;
                tx_active_o <= (nxt == ST_TX);
            end
        end
    end

`ifdef JB_PA_SEQ_STATUS_EN
    assign seq_state_o = state;

    // Saturating count of aborted TX settles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_cnt_o <= '0;
        end else if (ovr_q) begin
            abort_cnt_o <= '0;
        end else if (state == ST_TX_SETTLE &&
                     nxt == ST_RX_SETTLE &&
                     abort_cnt_o != '1) begin
            abort_cnt_o <= abort_cnt_o + 16'd1;
        end
    end
`endif

endmodule
